// File: rtl/camera_config_sccb.sv
// camera_config_sccb
// Walks the OV7670 configuration ROM after a start request and sends each
// entry to the sensor as an SCCB 3-phase write {ID, sub-address, value}.
// Entry 16'hFFF0 inserts a fixed wait and 16'hFFFF ends the table.
// The block only drives the bus: SIOD is never sampled and slave ACKs are
// not checked.

module camera_config_sccb #(
   parameter int         CLK_FREQ_HZ  = 25_000_000,
   parameter int         SCCB_FREQ_HZ = 100_000,
   parameter int         DELAY_MS     = 10,
   parameter logic [7:0] DEV_ID       = 8'h42
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic [7:0]  rom_select,
   input  logic [15:0] rom_out,
   output logic        sioc,
   output logic        siod_oe,
   output logic        busy,
   output logic        done
);

   localparam int QDIV         = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);
   localparam int DELAY_CYCLES = (CLK_FREQ_HZ / 1000) * DELAY_MS;
   localparam int QW           = (QDIV > 1) ? $clog2(QDIV) : 1;
   localparam logic [QW-1:0] QLAST = QW'(QDIV - 1);
   localparam logic [31:0]   DLAST = 32'(DELAY_CYCLES - 1);

   typedef enum logic [3:0] {
      IDLE,
      FETCH,
      DECODE,
      TX_START,
      TX_BITS,
      TX_STOP,
      GAP,
      DELAY,
      DONE
   } state_t;

   state_t state, state_n;

   logic [QW-1:0] qcnt, qcnt_n;
   logic [1:0]    qtr, qtr_n;
   logic [31:0]   dcnt, dcnt_n;
   logic [4:0]    bit_idx, bit_n;
   logic [26:0]   frame, frame_n;
   logic [7:0]    rom_select_n;
   logic          sioc_n, siod_oe_n, busy_n, done_n;
   logic          q_end, advance;

   // State register; reset returns the sequencer to IDLE immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Datapath and bus pin registers; the pins come straight from flops so they never glitch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rom_select <= 8'd0;
         sioc       <= 1'b1;
         siod_oe    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         frame      <= '0;
         bit_idx    <= '0;
         qcnt       <= '0;
         qtr        <= '0;
         dcnt       <= '0;
      end else begin
         rom_select <= rom_select_n;
         sioc       <= sioc_n;
         siod_oe    <= siod_oe_n;
         busy       <= busy_n;
         done       <= done_n;
         frame      <= frame_n;
         bit_idx    <= bit_n;
         qcnt       <= qcnt_n;
         qtr        <= qtr_n;
         dcnt       <= dcnt_n;
      end
   end

   // Next-state logic: pin values are computed one cycle ahead so each change lands exactly on a quarter boundary.
   always_comb begin
      state_n      = state;
      rom_select_n = rom_select;
      sioc_n       = sioc;
      siod_oe_n    = siod_oe;
      busy_n       = busy;
      done_n       = done;
      frame_n      = frame;
      bit_n        = bit_idx;
      advance      = 1'b0;
      q_end        = (qcnt == QLAST);
      qcnt_n       = q_end ? '0 : qcnt + 1'b1;
      qtr_n        = q_end ? qtr + 2'd1 : qtr;
      dcnt_n       = (state == DELAY) ? dcnt + 32'd1 : dcnt;

      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_n      = FETCH;
               rom_select_n = 8'd0;
               busy_n       = 1'b1;
               done_n       = 1'b0;
            end
         end

         FETCH: begin
            state_n = DECODE;
         end

         DECODE: begin
            if (rom_out == 16'hFFFF) begin
               state_n = DONE;
               busy_n  = 1'b0;
               done_n  = 1'b1;
            end else if (rom_out == 16'hFFF0) begin
               state_n = DELAY;
            end else begin
               frame_n   = {DEV_ID, 1'b1, rom_out[15:8], 1'b1, rom_out[7:0], 1'b1};
               bit_n     = 5'd0;
               sioc_n    = 1'b1;
               siod_oe_n = 1'b1;
               state_n   = TX_START;
            end
         end

         TX_START: begin
            if (q_end && qtr == 2'd1) begin
               state_n   = TX_BITS;
               sioc_n    = 1'b0;
               siod_oe_n = ~frame[26];
            end
         end

         TX_BITS: begin
            if (q_end) begin
               case (qtr)
                  2'd1: sioc_n = 1'b1;
                  2'd3: begin
                     sioc_n = 1'b0;
                     if (bit_idx == 5'd26) begin
                        state_n   = TX_STOP;
                        siod_oe_n = 1'b1;
                     end else begin
                        bit_n     = bit_idx + 5'd1;
                        frame_n   = {frame[25:0], 1'b0};
                        siod_oe_n = ~frame[25];
                     end
                  end
                  default: ;
               endcase
            end
         end

         TX_STOP: begin
            if (q_end) begin
               case (qtr)
                  2'd1: sioc_n    = 1'b1;
                  2'd2: siod_oe_n = 1'b0;
                  2'd3: state_n   = GAP;
                  default: ;
               endcase
            end
         end

         GAP: begin
            if (q_end && qtr == 2'd3) begin
               advance = 1'b1;
            end
         end

         DELAY: begin
            if (dcnt == DLAST) begin
               advance = 1'b1;
            end
         end

         default: begin
            state_n = IDLE;
         end
      endcase

      if (advance) begin
         if (rom_select == 8'hFF) begin
            state_n = DONE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
         end else begin
            rom_select_n = rom_select + 8'd1;
            state_n      = FETCH;
         end
      end

      if (state_n != state) begin
         qcnt_n = '0;
         qtr_n  = '0;
         dcnt_n = '0;
      end
   end

endmodule

// File: tb/tb_camera_config_sccb.sv
// tb_camera_config_sccb
// Drives camera_config_sccb from a registered ROM model. Expected writes and
// end-of-table events are derived from the table contents and queued; bus
// monitors decode SIOC/SIOD into frames and compare against the queue.
// A second instance with a quarter of one clock runs the full 256-entry table.

module tb_camera_config_sccb;

   localparam int TB_CLK       = 4_000_000;
   localparam int TB_SCCB      = 100_000;
   localparam int TB_DELAY_MS  = 1;
   localparam int DELAY_CYCLES = (TB_CLK / 1000) * TB_DELAY_MS;

   typedef struct packed {
      logic       is_done;
      logic [7:0] id;
      logic [7:0] sub;
      logic [7:0] val;
      logic [7:0] sel;
   } item_t;

   typedef struct packed {
      logic        in_frame;
      logic        prev_sioc;
      logic        prev_sda;
      logic [31:0] cnt;
      logic [27:0] word;
   } mon_t;

   logic        clk;
   logic        rst_n;
   logic        start, start_f;
   logic [7:0]  rom_select, rom_select_f;
   logic [15:0] rom_out, rom_out_f;
   logic        sioc, siod_oe, busy, done;
   logic        sioc_f, siod_oe_f, busy_f, done_f;

   logic [15:0] rom      [256];
   logic [15:0] rom_fast [256];

   item_t exp_q[$];
   item_t exp_f[$];

   int total = 0;
   int bad   = 0;
   int frames_f = 0;
   int watch_hits = 0;
   logic [7:0] watch_idx = 8'd0;

   mon_t mon, mon_f;
   logic done_prev, done_prev_f;
   logic [7:0] sel_prev;

   camera_config_sccb #(
      .CLK_FREQ_HZ (TB_CLK),
      .SCCB_FREQ_HZ(TB_SCCB),
      .DELAY_MS    (TB_DELAY_MS),
      .DEV_ID      (8'h42)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .rom_select(rom_select),
      .rom_out   (rom_out),
      .sioc      (sioc),
      .siod_oe   (siod_oe),
      .busy      (busy),
      .done      (done)
   );

   camera_config_sccb #(
      .CLK_FREQ_HZ (400_000),
      .SCCB_FREQ_HZ(100_000),
      .DELAY_MS    (1),
      .DEV_ID      (8'h42)
   ) dut_fast (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start_f),
      .rom_select(rom_select_f),
      .rom_out   (rom_out_f),
      .sioc      (sioc_f),
      .siod_oe   (siod_oe_f),
      .busy      (busy_f),
      .done      (done_f)
   );

   // Free-running system clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Registered ROM models: one cycle from rom_select to rom_out.
   always @(posedge clk) begin
      rom_out   <= rom[rom_select];
      rom_out_f <= rom_fast[rom_select_f];
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   function automatic mon_t busStep(input mon_t m, input logic scl, input logic sda, output logic got);
      mon_t r;
      r   = m;
      got = 1'b0;
      if (scl && m.prev_sioc && m.prev_sda && !sda) begin
         r.in_frame = 1'b1;
         r.cnt      = 32'd0;
         r.word     = '0;
      end else if (scl && m.prev_sioc && !m.prev_sda && sda && m.in_frame) begin
         r.in_frame = 1'b0;
         got        = 1'b1;
      end else if (scl && !m.prev_sioc && m.in_frame) begin
         r.word = {m.word[26:0], sda};
         r.cnt  = m.cnt + 32'd1;
      end
      r.prev_sioc = scl;
      r.prev_sda  = sda;
      return r;
   endfunction

   function automatic mon_t monIdle();
      mon_t r;
      r           = '0;
      r.prev_sioc = 1'b1;
      r.prev_sda  = 1'b1;
      return r;
   endfunction

   // Reference model: walk the table by its rules and queue what the bus should show.
   function automatic void pushModel(input bit fast);
      logic [15:0] e;
      item_t it;
      for (int i = 0; i < 256; i++) begin
         e = fast ? rom_fast[i] : rom[i];
         it = '0;
         it.sel = 8'(i);
         if (e == 16'hFFFF) begin
            it.is_done = 1'b1;
            if (fast) exp_f.push_back(it); else exp_q.push_back(it);
            return;
         end
         if (e != 16'hFFF0) begin
            it.id  = 8'h42;
            it.sub = e[15:8];
            it.val = e[7:0];
            if (fast) exp_f.push_back(it); else exp_q.push_back(it);
         end
      end
      it = '0;
      it.is_done = 1'b1;
      it.sel = 8'd255;
      if (fast) exp_f.push_back(it); else exp_q.push_back(it);
   endfunction

   task automatic checkFrame(input item_t e, input mon_t m, input logic [7:0] sel);
      checkOutput("frame_bits", m.cnt, 28);
      checkOutput("frame_id", m.word[27:20], e.id);
      checkOutput("frame_sub", m.word[18:11], e.sub);
      checkOutput("frame_val", m.word[9:2], e.val);
      checkOutput("frame_dontcare", {m.word[19], m.word[10], m.word[1], m.word[0]}, 4'b1110);
      checkOutput("frame_index", sel, e.sel);
   endtask

   // Main bus monitor: decode each frame and match it, and every done rise, against the queue.
   always @(negedge clk) begin
      logic got;
      item_t e;
      if (!rst_n) begin
         mon       = monIdle();
         done_prev = 1'b0;
         sel_prev  = rom_select;
      end else begin
         mon = busStep(mon, sioc, ~siod_oe, got);
         if (got) begin
            if (exp_q.size() == 0 || exp_q[0].is_done) begin
               total++;
               bad++;
               $display("[TB] FAIL sb_frame: got unexpected frame 0x%0h, required no frame", mon.word);
            end else begin
               e = exp_q.pop_front();
               checkFrame(e, mon, rom_select);
            end
         end
         if (done && !done_prev) begin
            if (exp_q.size() == 0 || !exp_q[0].is_done) begin
               total++;
               bad++;
               $display("[TB] FAIL sb_done: got done at index %0d, required a frame first", rom_select);
            end else begin
               e = exp_q.pop_front();
               checkOutput("done_index", rom_select, e.sel);
               checkOutput("done_busy", busy, 0);
            end
         end
         if (rom_select == watch_idx && sel_prev != watch_idx) watch_hits++;
         done_prev = done;
         sel_prev  = rom_select;
      end
   end

   // Monitor for the fast instance used for the full-table run.
   always @(negedge clk) begin
      logic got;
      item_t e;
      if (!rst_n) begin
         mon_f       = monIdle();
         done_prev_f = 1'b0;
      end else begin
         mon_f = busStep(mon_f, sioc_f, ~siod_oe_f, got);
         if (got) begin
            frames_f++;
            if (exp_f.size() == 0 || exp_f[0].is_done) begin
               total++;
               bad++;
               $display("[TB] FAIL sb_frame_fast: got unexpected frame 0x%0h, required no frame", mon_f.word);
            end else begin
               e = exp_f.pop_front();
               checkFrame(e, mon_f, rom_select_f);
            end
         end
         if (done_f && !done_prev_f) begin
            if (exp_f.size() == 0 || !exp_f[0].is_done) begin
               total++;
               bad++;
               $display("[TB] FAIL sb_done_fast: got done at index %0d, required a frame first", rom_select_f);
            end else begin
               e = exp_f.pop_front();
               checkOutput("done_index_fast", rom_select_f, e.sel);
            end
         end
         done_prev_f = done_f;
      end
   end

   task automatic applyStimulus(input bit fast);
      @(negedge clk);
      if (fast) start_f = 1'b1; else start = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      start_f = 1'b0;
      if (fast) checkOutput("start_state_fast", {busy_f, done_f}, 2'b10);
      else      checkOutput("start_state", {busy, done}, 2'b10);
   endtask

   task automatic waitDone(input bit fast, input int bound, input string name);
      int n;
      n = 0;
      while (n < bound && !(fast ? done_f : done)) begin
         @(negedge clk);
         n++;
      end
      checkOutput(name, fast ? done_f : done, 1);
      repeat (2) @(negedge clk);
      checkOutput({name, "_drained"}, fast ? exp_f.size() : exp_q.size(), 0);
   endtask

   task automatic clearTable();
      for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
   endtask

   function automatic logic [15:0] randEntry();
      logic [7:0] hi, lo;
      hi = 8'($urandom_range(0, 254));
      lo = 8'($urandom_range(0, 255));
      return {hi, lo};
   endfunction

   // Top-level sequence of directed and randomized scenarios.
   initial begin
      int cnt, idle_bad, n;
      rst_n   = 1'b0;
      start   = 1'b0;
      start_f = 1'b0;
      clearTable();
      for (int i = 0; i < 256; i++) rom_fast[i] = 16'h0C00;

      // reset holds every output at its idle value even with start toggling
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         start = ~start;
         #1;
         checkOutput("reset_outputs", {rom_select, sioc, siod_oe, busy, done}, {8'd0, 4'b1000});
      end
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // single soft-reset write, with start latency
      rom[0] = 16'h1280;
      rom[1] = 16'hFFFF;
      pushModel(1'b0);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      checkOutput("lat_n1", {busy, rom_select}, {1'b1, 8'd0});
      @(posedge clk);
      #1;
      checkOutput("lat_n2_oe", siod_oe, 0);
      @(posedge clk);
      #1;
      checkOutput("lat_n3_start", {sioc, siod_oe}, 2'b11);
      waitDone(1'b0, 3000, "t2_done");

      // delay entry followed by a write, restarted from DONE
      clearTable();
      rom[0] = 16'hFFF0;
      rom[1] = 16'h1180;
      pushModel(1'b0);
      applyStimulus(1'b0);
      cnt = 0;
      idle_bad = 0;
      for (int i = 0; i < 6000; i++) begin
         if (rom_select != 8'd0) break;
         cnt++;
         if (sioc !== 1'b1 || siod_oe !== 1'b0) idle_bad++;
         @(negedge clk);
      end
      checkOutput("delay_cycles", cnt, DELAY_CYCLES + 2);
      checkOutput("delay_idle", idle_bad, 0);
      waitDone(1'b0, 3000, "t3_done");

      // start pulses while busy are ignored
      clearTable();
      for (int i = 0; i < 5; i++) rom[i] = randEntry();
      pushModel(1'b0);
      watch_idx  = 8'd5;
      watch_hits = 0;
      applyStimulus(1'b0);
      repeat (600) @(negedge clk);
      applyStimulus(1'b0);
      repeat (2000) @(negedge clk);
      applyStimulus(1'b0);
      waitDone(1'b0, 8000, "t4_done");
      checkOutput("t4_marker_once", watch_hits, 1);

      // reset during the second byte abandons the frame; a new start resends all
      clearTable();
      for (int i = 0; i < 3; i++) rom[i] = randEntry();
      pushModel(1'b0);
      applyStimulus(1'b0);
      repeat (470) @(negedge clk);
      checkOutput("t5_mid_bit_sioc", sioc, 0);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("t5_reset_bus", {sioc, siod_oe}, 2'b10);
      checkOutput("t5_reset_state", {rom_select, busy, done}, {8'd0, 2'b00});
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      pushModel(1'b0);
      applyStimulus(1'b0);
      waitDone(1'b0, 5000, "t5_done");

      // randomized short tables
      for (int r = 0; r < 2; r++) begin
         clearTable();
         n = $urandom_range(2, 3);
         for (int i = 0; i < n; i++) rom[i] = randEntry();
         pushModel(1'b0);
         applyStimulus(1'b0);
         waitDone(1'b0, 5000, "rand_done");
      end

      // table without end marker runs all 256 entries
      frames_f = 0;
      pushModel(1'b1);
      applyStimulus(1'b1);
      waitDone(1'b1, 35000, "t6_done");
      checkOutput("t6_index", rom_select_f, 255);
      checkOutput("t6_frames", frames_f, 256);
      checkOutput("t6_busy", busy_f, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #1_500_000;
      $display("[TB] FAIL watchdog: got time limit, required completion");
      $fatal(1, "[TB] time limit reached");
   end

endmodule

// File: doc/camera_config_sccb.md
# camera_config_sccb

Sequencer and SCCB write master that brings up the OV7670 camera after reset. It walks the camera configuration ROM index by index, reads each 16-bit entry (sub-address in the high byte, value in the low byte), and sends it to the sensor as an SCCB 3-phase write. The ROM marks a delay with 16'hFFF0 and the end of the table with 16'hFFFF. This block sits directly downstream of the configuration ROM and drives the camera's SIOC/SIOD pins.

## Interface
- CLK_FREQ_HZ, 25_000_000, frequency of `clk`
- SCCB_FREQ_HZ, 100_000, SIOC bit rate
- DELAY_MS, 10, wait applied for each 16'hFFF0 entry
- DEV_ID, 8'h42, SCCB write address (ID phase byte)

- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to run the table from index 0
- rom_select  out  8  ROM index; ROM output is registered (1-cycle latency)
- rom_out  in  16  ROM entry for the previous cycle's rom_select
- sioc  out  1  SCCB clock, push-pull
- siod_oe  out  1  1 = pull SIOD pad low; 0 = release (external pull-up gives high)
- busy  out  1  high from the start acceptance until done
- done  out  1  high after the end marker; held until next start or reset

## Operation
- Constants:
  - QDIV = CLK_FREQ_HZ/(4*SCCB_FREQ_HZ) cycles per quarter bit; 62 at defaults.
  - DELAY_CYCLES = (CLK_FREQ_HZ/1000)*DELAY_MS.
  - The quarter counter and the 32-bit delay counter both reload to 0 on every state entry.
- FSM states: IDLE, FETCH, DECODE, TX_START, TX_BITS, TX_STOP, GAP, DELAY, DONE.
- IDLE and DONE:
  - `start`=1 → rom_select←0, busy←1, done←0, go to FETCH.
  - `start` is ignored in every other state.
- FETCH: wait 1 cycle for ROM latency, then DECODE.
- DECODE (checks are ordered):
  - rom_out==16'hFFFF → DONE (busy←0, done←1).
  - rom_out==16'hFFF0 → DELAY.
  - Otherwise, latch the 27-bit frame {DEV_ID,1'b1, rom_out[15:8],1'b1, rom_out[7:0],1'b1} and go to TX_START.
  - The 1'b1 in the 9th bit of each byte is the don't-care slot, sent with SIOD released.
  - Entry 16'h1280 (soft reset) is transmitted like any other entry.
- TX_START, 2 quarters: siod_oe=1 while sioc=1 (start condition).
- TX_BITS: 27 bits, MSB first, 4 quarters per bit.
  - q0, q1: sioc=0.
  - q2, q3: sioc=1.
  - siod_oe = ~bit, updated at the start of q0 only.
- TX_STOP, 4 quarters:
  - q0, q1: sioc=0, siod_oe=1.
  - q2: sioc=1.
  - q3: siod_oe=0 (stop condition).
- GAP: 4 quarters with the bus idle (sioc=1, siod_oe=0), then advance.
- DELAY: DELAY_CYCLES cycles with the bus idle, then advance.
- Advance:
  - rom_select<255 → rom_select+1, go to FETCH.
  - rom_select==255 → DONE.
- The block never samples SIOD and does not check slave ACK.

## Timing
- Reset values: rom_select=0, sioc=1, siod_oe=0, busy=0, done=0, state IDLE.
- Reset mid-frame: outputs return to their reset values immediately (asynchronously). A partial frame is abandoned, not completed.
- Start latency, with `start` sampled at edge N:
  - N+1: busy=1, rom_select=0.
  - N+2: DECODE.
  - N+3: siod_oe rises (start condition).
- One frame occupies 2+108+4 = 114 quarters on the bus, plus 4 GAP quarters, plus 2 cycles of FETCH and DECODE.
- Delay entry: DELAY_CYCLES + 2 cycles from rom_select update to the next rom_select update.
- `done` rises in the cycle after DECODE sees 16'hFFFF, and busy falls in the same cycle.
- `start` arriving in the same cycle as the DONE transition is ignored. `start` in DONE restarts from index 0.
- sioc and siod_oe are registered outputs and are glitch-free.

## Test plan
Bench parameters: CLK_FREQ_HZ=4_000_000, SCCB_FREQ_HZ=100_000 (QDIV=10), DELAY_MS=1 (DELAY_CYCLES=4000). The ROM model is registered.

- Reset with rst_n=0, start toggling → sioc=1, siod_oe=0, busy=0, done=0, rom_select=0 throughout.
- ROM {0:16'h1280, 1:16'hFFFF}, pulse start → SIOD falls while SIOC=1. Decoding SIOD on SIOC rising edges gives bytes 0x42, 0x12, 0x80, each followed by a released 9th bit. Then the stop condition, then done=1 and busy=0.
- ROM {0:16'hFFF0, 1:16'h1180, 2:16'hFFFF} → exactly 4002 cycles between rom_select 0→1 with the bus idle. The frame 0x42, 0x11, 0x80 follows, then done.
- Pulse start again mid-frame of a 5-entry table → no restart. Exactly 5 frames are sent, and rom_select reaches the FFFF index once.
- Drop rst_n during the 2nd byte → sioc=1 and siod_oe=0 in the same cycle. After release and a new start, the full table resends from index 0.
- Table with no FFFF marker (all 256 entries 16'h0C00) → 256 frames, then done=1 with rom_select=255.
